// File: rtl/systolic_data_setup_if.sv
// Row handshake and skewed-output bundle between the unified buffer and the
// data-setup block that feeds the PE array's left edge.
interface systolic_data_setup_if #(
  parameter int N  = 256,
  parameter int W  = 8,
  parameter int CW = 16
);
  logic                start;
  logic [CW-1:0]       num_vec;
  logic                in_valid;
  logic                in_ready;
  logic [0:N-1][W-1:0] in_data;
  logic [0:N-1][W-1:0] left_out;
  logic                lane0_valid;
  logic                busy;
  logic                done;

  modport master (
    output start, num_vec, in_valid, in_data,
    input  in_ready, left_out, lane0_valid, busy, done
  );

  modport slave (
    input  start, num_vec, in_valid, in_data,
    output in_ready, left_out, lane0_valid, busy, done
  );
endinterface

// File: rtl/systolic_data_setup.sv
// Diagonal skew feeder for the PE array left edge: lane i lags lane 0 by i cycles,
// with a small job FSM that feeds num_vec rows, drains zeros, then pulses done.
module systolic_data_setup #(
  parameter int N  = 256,
  parameter int W  = 8,
  parameter int CW = 16
) (
  input logic                  clk,
  input logic                  reset,
  systolic_data_setup_if.slave dsBus
);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_e;

  localparam int DW = (N > 1) ? $clog2(N) : 1;

  state_e              state_q, state_d;
  logic [CW-1:0]       numVec_q, numVec_d;
  logic [CW-1:0]       rowCount_q, rowCount_d;
  logic [CW-1:0]       rowNext;
  logic [DW-1:0]       drainCount_q, drainCount_d;
  logic                done_q, done_d;
  logic                lane0Valid_q;
  logic                accept;
  logic [0:N-1][W-1:0] leftOut;
  wire  [W-1:0]        laneOut [N];

  assign accept  = dsBus.in_valid && (state_q == FEED);
  assign rowNext = rowCount_q + CW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      numVec_q     <= '0;
      rowCount_q   <= '0;
      drainCount_q <= '0;
      done_q       <= 1'b0;
      lane0Valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      numVec_q     <= numVec_d;
      rowCount_q   <= rowCount_d;
      drainCount_q <= drainCount_d;
      done_q       <= done_d;
      lane0Valid_q <= accept;
    end
  end

  always_comb begin
    state_d      = state_q;
    numVec_d     = numVec_q;
    rowCount_d   = rowCount_q;
    drainCount_d = drainCount_q;
    case (state_q)
      IDLE: begin
        if (dsBus.start && (dsBus.num_vec != '0)) begin
          numVec_d   = dsBus.num_vec;
          rowCount_d = '0;
          state_d    = FEED;
        end
      end
      FEED: begin
        if (accept) begin
          rowCount_d = rowNext;
          if (rowNext == numVec_q) begin
            state_d      = DRAIN;
            drainCount_d = DW'(N - 1);
          end
        end
      end
      DRAIN: begin
        if (drainCount_q == '0) begin
          state_d = IDLE;
        end else begin
          drainCount_d = drainCount_q - DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // done covers both the empty job and the end of the drain window
  always_comb begin
    done_d = 1'b0;
    if ((state_q == IDLE) && dsBus.start && (dsBus.num_vec == '0)) begin
      done_d = 1'b1;
    end
    if ((state_q == DRAIN) && (drainCount_q == '0)) begin
      done_d = 1'b1;
    end
  end

  // Chains never stall: the array has no back-pressure, so bubbles shift in as zeros
  for (genvar i = 0; i < N; i++) begin : gLane
    logic [W-1:0] chain_q [0:i];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int k = 0; k <= i; k++) begin
          chain_q[k] <= '0;
        end
      end else begin
        chain_q[0] <= accept ? dsBus.in_data[i] : '0;
        for (int k = 1; k <= i; k++) begin
          chain_q[k] <= chain_q[k-1];
        end
      end
    end

    assign laneOut[i] = chain_q[i];
  end

  always_comb begin
    leftOut = '0;
    for (int i = 0; i < N; i++) begin
      leftOut[i] = laneOut[i];
    end
  end

  assign dsBus.in_ready    = (state_q == FEED);
  assign dsBus.busy        = (state_q != IDLE);
  assign dsBus.done        = done_q;
  assign dsBus.lane0_valid = lane0Valid_q;
  assign dsBus.left_out    = leftOut;

endmodule

// File: tb/tb_systolic_data_setup.sv
// Directed bench for systolic_data_setup with a job-level reference model
// compared against every DUT output on each falling clock edge.
module tb_systolic_data_setup;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int CW = 4;

  typedef logic [0:N-1][W-1:0] row_t;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  systolic_data_setup_if #(.N(N), .W(W), .CW(CW)) bus ();

  systolic_data_setup #(.N(N), .W(W), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .dsBus (bus)
  );

  always #5 clk = ~clk;

  // Model: every accepted row is stamped with its edge number; lane i shows the row from i edges ago
  int   cyc      = 0;
  int   mode     = 0;
  int   rowsLeft = 0;
  int   doneAt   = -1;
  bit   modelAcc;
  row_t hist [int];
  bit   histV [int];
  bit   sawFF      = 1'b0;
  int   lane0Count = 0;
  row_t ffRow;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d time=%0t", name, actual, expected, $time);
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode     = 0;
      rowsLeft = 0;
      doneAt   = -1;
      hist.delete();
      histV.delete();
    end else begin
      cyc++;
      modelAcc   = (bus.in_valid === 1'b1) && (mode == 1);
      hist[cyc]  = modelAcc ? bus.in_data : '0;
      histV[cyc] = modelAcc;
      case (mode)
        0: begin
          if (bus.start === 1'b1) begin
            if (bus.num_vec == '0) begin
              doneAt = cyc;
            end else begin
              mode     = 1;
              rowsLeft = int'(bus.num_vec);
            end
          end
        end
        1: begin
          if (modelAcc) begin
            rowsLeft--;
            if (rowsLeft == 0) begin
              mode   = 2;
              doneAt = cyc + N;
            end
          end
        end
        default: begin
          if (cyc == doneAt) mode = 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin : compareProc
    int expLane;
    for (int i = 0; i < N; i++) begin
      expLane = hist.exists(cyc - i) ? int'(hist[cyc - i][i]) : 0;
      checkOutput($sformatf("left_out[%0d]", i), int'(bus.left_out[i]), expLane);
      if (bus.left_out[i] == 8'hFF) sawFF = 1'b1;
    end
    checkOutput("lane0_valid", int'(bus.lane0_valid),
                (histV.exists(cyc) && histV[cyc]) ? 1 : 0);
    checkOutput("in_ready", int'(bus.in_ready), (mode == 1) ? 1 : 0);
    checkOutput("busy", int'(bus.busy), (mode != 0) ? 1 : 0);
    checkOutput("done", int'(bus.done), (doneAt == cyc) ? 1 : 0);
    if (bus.lane0_valid === 1'b1) lane0Count++;
  end

  function automatic row_t mkRow(input int r);
    row_t rr;
    for (int i = 0; i < N; i++) rr[i] = W'(16 * (r + 1) + i + 1);
    return rr;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit st, input int nv, input bit v, input row_t d);
    bus.start    = st;
    bus.num_vec  = CW'(nv);
    bus.in_valid = v;
    bus.in_data  = d;
    tick();
  endtask

  // Returns the number of edges from the start edge up to the one after which done is seen
  task automatic runJob(input int nv, input int gap, output int ticks);
    ticks = 0;
    applyStimulus(1'b1, nv, 1'b0, '0);
    ticks++;
    for (int r = 0; r < nv; r++) begin
      if (r == 1) begin
        repeat (gap) begin
          applyStimulus(1'b0, nv, 1'b0, '0);
          ticks++;
        end
      end
      applyStimulus(1'b0, nv, 1'b1, mkRow(r));
      ticks++;
    end
    bus.in_valid = 1'b0;
    while (bus.done !== 1'b1 && ticks < 200) begin
      tick();
      ticks++;
    end
    if (bus.done !== 1'b1) checkOutput("job_timeout", 0, 1);
  endtask

  initial begin
    int   t0;
    int   t1;
    row_t rowA;
    row_t rowB;
    rowA  = {8'd1, 8'd2, 8'd3, 8'd4};
    rowB  = {8'd5, 8'd6, 8'd7, 8'd8};
    ffRow = {N{8'hFF}};

    reset        = 1'b0;
    bus.start    = 1'b0;
    bus.num_vec  = '0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    #8;
    checkOutput("reset_busy", int'(bus.busy), 0);
    checkOutput("reset_done", int'(bus.done), 0);
    checkOutput("reset_in_ready", int'(bus.in_ready), 0);
    checkOutput("reset_lane0_valid", int'(bus.lane0_valid), 0);
    checkOutput("reset_left_out", int'(bus.left_out), 0);
    #4;
    reset = 1'b1;
    tick();

    // Two back-to-back rows, literal latencies
    applyStimulus(1'b1, 2, 1'b0, '0);
    lane0Count = 0;
    applyStimulus(1'b0, 2, 1'b1, rowA);
    checkOutput("t_lane0", int'(bus.left_out[0]), 1);
    checkOutput("t_lane0_valid", int'(bus.lane0_valid), 1);
    applyStimulus(1'b0, 2, 1'b1, rowB);
    checkOutput("t1_lane0", int'(bus.left_out[0]), 5);
    checkOutput("t1_lane1", int'(bus.left_out[1]), 2);
    applyStimulus(1'b0, 2, 1'b0, '0);
    checkOutput("t2_lane0", int'(bus.left_out[0]), 0);
    checkOutput("t2_lane1", int'(bus.left_out[1]), 6);
    checkOutput("t2_lane2", int'(bus.left_out[2]), 3);
    checkOutput("t2_in_ready", int'(bus.in_ready), 0);
    checkOutput("t2_busy", int'(bus.busy), 1);
    tick();
    checkOutput("t3_lane3", int'(bus.left_out[3]), 4);
    tick();
    checkOutput("t4_lane3", int'(bus.left_out[3]), 8);
    checkOutput("t4_done", int'(bus.done), 0);
    tick();
    checkOutput("t5_done", int'(bus.done), 1);
    checkOutput("t5_busy", int'(bus.busy), 0);
    tick();
    checkOutput("t6_done", int'(bus.done), 0);
    checkOutput("lane0_valid_cycles", lane0Count, 2);

    // Bubbles delay done by exactly the gap length
    runJob(3, 0, t0);
    checkOutput("nogap_ticks", t0, 8);
    lane0Count = 0;
    runJob(3, 2, t1);
    checkOutput("gap_ticks", t1, 10);
    checkOutput("gap_lane0_valid_cycles", lane0Count, 3);

    // Empty job, issued while the previous done is still high
    applyStimulus(1'b1, 0, 1'b0, '0);
    checkOutput("nv0_done", int'(bus.done), 1);
    checkOutput("nv0_busy", int'(bus.busy), 0);
    checkOutput("nv0_in_ready", int'(bus.in_ready), 0);
    applyStimulus(1'b0, 0, 1'b0, '0);
    checkOutput("nv0_done_off", int'(bus.done), 0);
    checkOutput("nv0_busy_after", int'(bus.busy), 0);

    // start during FEED and DRAIN is ignored
    t0 = 0;
    applyStimulus(1'b1, 2, 1'b0, '0);          t0++;
    applyStimulus(1'b1, 7, 1'b1, mkRow(0));    t0++;
    applyStimulus(1'b1, 5, 1'b1, mkRow(1));    t0++;
    applyStimulus(1'b1, 3, 1'b0, '0);          t0++;
    bus.start = 1'b0;
    while (bus.done !== 1'b1 && t0 < 200) begin
      tick();
      t0++;
    end
    checkOutput("ignored_start_ticks", t0, 7);

    // start coincident with done begins a new job
    applyStimulus(1'b1, 1, 1'b0, '0);
    checkOutput("coincident_busy", int'(bus.busy), 1);
    checkOutput("coincident_in_ready", int'(bus.in_ready), 1);
    applyStimulus(1'b0, 1, 1'b1, mkRow(2));
    t0 = 0;
    while (bus.done !== 1'b1 && t0 < 200) begin
      tick();
      t0++;
    end
    checkOutput("coincident_drain_ticks", t0, 4);

    // in_valid outside FEED must be dropped
    sawFF = 1'b0;
    applyStimulus(1'b0, 1, 1'b1, ffRow);
    applyStimulus(1'b0, 1, 1'b1, ffRow);
    checkOutput("idle_in_ready", int'(bus.in_ready), 0);
    applyStimulus(1'b1, 1, 1'b0, '0);
    applyStimulus(1'b0, 1, 1'b1, mkRow(3));
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1, 1'b1, ffRow);
      checkOutput("drain_in_ready", int'(bus.in_ready), 0);
    end
    bus.in_valid = 1'b0;
    repeat (3) tick();
    checkOutput("ff_never_seen", int'(sawFF), 0);

    // Asynchronous reset mid-FEED abandons the job
    applyStimulus(1'b1, 5, 1'b0, '0);
    applyStimulus(1'b0, 5, 1'b1, mkRow(0));
    applyStimulus(1'b0, 5, 1'b1, mkRow(1));
    bus.in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    checkOutput("rst_left_out", int'(bus.left_out), 0);
    checkOutput("rst_busy", int'(bus.busy), 0);
    checkOutput("rst_in_ready", int'(bus.in_ready), 0);
    checkOutput("rst_done", int'(bus.done), 0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      checkOutput("rst_no_done", int'(bus.done), 0);
    end
    runJob(1, 0, t0);
    checkOutput("post_reset_ticks", t0, 6);

    // Largest job the row counter can express
    runJob(15, 0, t0);
    checkOutput("max_num_vec_ticks", t0, 20);
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
